fifo_main_pop_ctrl: RTL



---
 rtl/fifo_main_pop_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_main_pop_ctrl.sv
// Pops the main FIFO head, decodes its VC id, and forwards the word to the VC demux through one register stage.
// Latency 1 cycle; Main_rd is held low by the selected almost-full (global or per-VC), and words with an out-of-range VC id are dropped.
module fifo_main_pop_ctrl #(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 2,
    parameter int VCID_LSB = 4,
    parameter int VCID_W   = 2,
    parameter int MODE     = 0,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    Main_empty,
    input  logic [DATA_W-1:0]       Main_data_out,
    input  logic [NUM_VC-1:0]       VC_almost_full,
    output logic                    Main_rd,
    output logic [DATA_W-1:0]       demux_vcid_in,
    output logic                    demux_vcid_valid_in,
    output logic                    vcid_err,
    output logic [1:0]              state,
    output logic [NUM_VC*CNT_W-1:0] dispatch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_BLOCKED  = 2'd2
    } state_t;

    localparam int              VC_SPACE = 1 << VCID_W;
    localparam logic [VCID_W:0] NUM_VC_L = (VCID_W+1)'(NUM_VC);

    logic [VCID_W-1:0]   vc;
    logic                in_range;
    logic [VC_SPACE-1:0] af_pad;
    logic                blocked;
    state_t              cur_st;
    state_t              nxt_st;

    assign vc       = Main_data_out[VCID_LSB +: VCID_W];
    assign in_range = {1'b0, vc} < NUM_VC_L;
    // Pad to the full id space so any id can index safely; unused ids read as not-full.
    assign af_pad   = VC_SPACE'(VC_almost_full);

    always_comb begin
        blocked = 1'b0;
        if (MODE == 0)
            blocked = |VC_almost_full;
        else
            blocked = in_range && af_pad[vc];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur_st <= ST_IDLE;
        else
            cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = ST_DISPATCH;
        if (Main_empty || !enable)
            nxt_st = ST_IDLE;
        else if (blocked)
            nxt_st = ST_BLOCKED;
    end

    always_comb begin
        Main_rd = !reset && enable && !Main_empty && !blocked;
    end

    assign state = cur_st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            demux_vcid_in       <= '0;
            demux_vcid_valid_in <= 1'b0;
            vcid_err            <= 1'b0;
        end else begin
            demux_vcid_in       <= (Main_rd && in_range) ? Main_data_out : '0;
            demux_vcid_valid_in <= Main_rd && in_range;
            vcid_err            <= Main_rd && !in_range;
        end
    end

    for (genvar k = 0; k < NUM_VC; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_q <= '0;
            else if (Main_rd && in_range && (vc == VCID_W'(k)))
                cnt_q <= cnt_q + CNT_W'(1);
        end
        assign dispatch_cnt[k*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
